// File: rtl/peak_fifo_if.sv
// Bus bundle for peak_fifo: frame capture inputs, FWFT read side, overflow status.
// The master modport belongs to the environment and the slave modport to the FIFO.
interface peak_fifo_if #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 9,
  parameter int AMPL_WIDTH = 24,
  parameter int TIME_WIDTH = 16,
  parameter int DEPTH      = 64
);
  localparam int BIN_W   = $clog2(PEAKS);
  localparam int ENTRY_W = TIME_WIDTH + BIN_W + FREQ_WIDTH + AMPL_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  // frame_valid is a one-cycle strobe with no ready: frames that cannot be taken are dropped
  logic                                  frame_valid;
  logic [PEAKS-1:0][AMPL_WIDTH-1:0]      amplitudes_in;
  logic [PEAKS-1:0][FREQ_WIDTH-1:0]      freqs_in;
  logic [TIME_WIDTH-1:0]                 counter_in;
  logic                                  rd_en;
  logic [ENTRY_W-1:0]                    rd_data;
  logic                                  empty;
  logic                                  full;
  logic [CNT_W-1:0]                      count;
  logic                                  overflow;
  logic                                  clear_overflow;
  logic [15:0]                           drop_count;
  logic                                  busy;
  logic                                  state_dbg;

  modport master (
    output frame_valid, amplitudes_in, freqs_in, counter_in, rd_en, clear_overflow,
    input  rd_data, empty, full, count, overflow, drop_count, busy, state_dbg
  );

  modport slave (
    input  frame_valid, amplitudes_in, freqs_in, counter_in, rd_en, clear_overflow,
    output rd_data, empty, full, count, overflow, drop_count, busy, state_dbg
  );
endinterface

// File: rtl/peak_fifo.sv
// Captures one peak set per frame, writes one band per cycle into an FWFT FIFO.
// Define PEAK_FIFO_KEEP_ZERO_EN to also store zero-amplitude bands.
module peak_fifo #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 9,
  parameter int AMPL_WIDTH = 24,
  parameter int TIME_WIDTH = 16,
  parameter int DEPTH      = 64
) (
  input  logic        clk,
  input  logic        reset,
  peak_fifo_if.slave  bus
);
  localparam int BIN_W   = $clog2(PEAKS);
  localparam int ENTRY_W = TIME_WIDTH + BIN_W + FREQ_WIDTH + AMPL_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int AW      = $clog2(DEPTH);
  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(PEAKS - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e                           state_q, state_d;
  logic [BIN_W-1:0]                 idx_q, idx_d;
  logic [PEAKS-1:0][AMPL_WIDTH-1:0] cap_ampl_q, cap_ampl_d;
  logic [PEAKS-1:0][FREQ_WIDTH-1:0] cap_freq_q, cap_freq_d;
  logic [TIME_WIDTH-1:0]            cap_time_q, cap_time_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             full_q, full_d, empty_q, empty_d;
  logic                             overflow_q, overflow_d;
  logic [15:0]                      drop_count_q, drop_count_d;
  logic [ENTRY_W-1:0]               mem_q [DEPTH];

  logic               busy, band_live, wr_en, rd_fire, drop_entry, drop_frame;
  logic [ENTRY_W-1:0] wr_entry;
  logic [1:0]         drop_inc;
  logic [16:0]        drop_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.frame_valid) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
  end

  always_comb begin
    idx_d      = idx_q;
    cap_ampl_d = cap_ampl_q;
    cap_freq_d = cap_freq_q;
    cap_time_d = cap_time_q;
    if (state_q == IDLE && bus.frame_valid) begin
      idx_d      = '0;
      cap_ampl_d = bus.amplitudes_in;
      cap_freq_d = bus.freqs_in;
      cap_time_d = bus.counter_in;
    end else if (state_q == SCAN) begin
      idx_d = idx_q + 1'b1;
    end
  end

`ifdef PEAK_FIFO_KEEP_ZERO_EN
  assign band_live = busy;
`else
  assign band_live = busy && (cap_ampl_q[idx_q] != '0);
`endif

  // Full is judged on the registered count, so a same-cycle read never frees room for a write
  assign wr_en      = band_live && !full_q;
  assign drop_entry = band_live && full_q;
  assign drop_frame = busy && bus.frame_valid;
  assign rd_fire    = bus.rd_en && !empty_q;
  assign wr_entry   = {cap_time_q, idx_q, cap_freq_q[idx_q], cap_ampl_q[idx_q]};
  assign drop_inc   = {1'b0, drop_entry} + {1'b0, drop_frame};
  assign drop_sum   = {1'b0, drop_count_q} + {15'd0, drop_inc};

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_fire);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    if (bus.clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      overflow_d   = overflow_q | drop_entry | drop_frame;
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      cap_ampl_q   <= '0;
      cap_freq_q   <= '0;
      cap_time_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      idx_q        <= idx_d;
      cap_ampl_q   <= cap_ampl_d;
      cap_freq_q   <= cap_freq_d;
      cap_time_q   <= cap_time_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Storage is not reset, so the head is forced to zero while nothing valid is held
  assign bus.rd_data    = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
  assign bus.busy       = busy;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_peak_fifo.sv
// Bench for peak_fifo: directed vector table and corner sequences plus random traffic,
// all checked against a queue-based model of frame capture, band timing and drops.
module tb_peak_fifo;
  localparam int PEAKS = 6, FREQ_WIDTH = 9, AMPL_WIDTH = 24, TIME_WIDTH = 16, DEPTH = 64;
  localparam int BIN_W   = $clog2(PEAKS);
  localparam int ENTRY_W = TIME_WIDTH + BIN_W + FREQ_WIDTH + AMPL_WIDTH;
`ifdef PEAK_FIFO_KEEP_ZERO_EN
  localparam bit KEEP_ZERO = 1'b1;
`else
  localparam bit KEEP_ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  peak_fifo_if bus ();
  peak_fifo dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [ENTRY_W-1:0]    exp_q[$];
  logic [AMPL_WIDTH-1:0] m_ampl[PEAKS];
  logic [FREQ_WIDTH-1:0] m_freq[PEAKS];
  logic [TIME_WIDTH-1:0] m_time;
  int cyc = 0;
  int t_acc = -1000;
  bit m_ovf = 1'b0;
  int m_dc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_scan(input int c);
    return (c - t_acc - 1 >= 0) && (c - t_acc - 1 < PEAKS);
  endfunction

  // Band k of the frame accepted in cycle t_acc is processed in cycle t_acc+1+k
  task automatic model_edge();
    int k, pre, inc;
    bit scanning;
    logic [BIN_W-1:0] kb;
    pre = exp_q.size();
    k = cyc - t_acc - 1;
    scanning = in_scan(cyc);
    inc = 0;
    if (bus.rd_en && pre > 0) void'(exp_q.pop_front());
    if (scanning && (KEEP_ZERO || m_ampl[k] != 0)) begin
      if (pre == DEPTH) inc++;
      else begin
        kb = k[BIN_W-1:0];
        exp_q.push_back({m_time, kb, m_freq[k], m_ampl[k]});
      end
    end
    if (bus.frame_valid) begin
      if (scanning) inc++;
      else begin
        t_acc = cyc;
        m_time = bus.counter_in;
        for (int i = 0; i < PEAKS; i++) begin
          m_ampl[i] = bus.amplitudes_in[i];
          m_freq[i] = bus.freqs_in[i];
        end
      end
    end
    if (bus.clear_overflow) begin
      m_ovf = 1'b0;
      m_dc = 0;
    end else if (inc > 0) begin
      m_ovf = 1'b1;
      m_dc = (m_dc + inc > 65535) ? 65535 : m_dc + inc;
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("empty", 64'(bus.empty), 64'(exp_q.size() == 0));
    chk("full", 64'(bus.full), 64'(exp_q.size() == DEPTH));
    chk("count", 64'(bus.count), 64'(exp_q.size()));
    chk("busy", 64'(bus.busy), 64'(in_scan(cyc)));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("drop_count", 64'(bus.drop_count), 64'(m_dc));
    if (exp_q.size() > 0) chk("rd_data", 64'(bus.rd_data), 64'(exp_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_frame(input bit allow_zero, input logic [TIME_WIDTH-1:0] t);
    for (int i = 0; i < PEAKS; i++) begin
      if (allow_zero && $urandom_range(0, 2) == 0) bus.amplitudes_in[i] = '0;
      else bus.amplitudes_in[i] = AMPL_WIDTH'($urandom_range(1, 32'h00FF_FFFF));
      bus.freqs_in[i] = FREQ_WIDTH'($urandom_range(0, 511));
    end
    bus.counter_in = t;
  endtask

  task automatic send_frame_and_scan();
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    repeat (PEAKS) step();
  endtask

  task automatic fill_eleven();
    for (int f = 0; f < 11; f++) begin
      rand_frame(1'b0, TIME_WIDTH'(f));
      send_frame_and_scan();
    end
  endtask

  typedef struct {
    logic               fv;
    logic               rd;
    int                 exp_count;
    logic               exp_empty;
    logic               exp_busy;
    logic [ENTRY_W-1:0] exp_head;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [ENTRY_W-1:0] e0, e1, e2, ez;
    int dc_before;
    e0 = {16'd5, 3'd0, 9'd3, 24'd10};
    e1 = {16'd5, 3'd2, 9'd40, 24'd30};
    e2 = {16'd5, 3'd5, 9'd200, 24'd60};
    ez = {16'd5, 3'd1, 9'd20, 24'd0};
    // Row i drives cycle T+i; expectations are observed in cycle T+i+1
    tbl[0]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, '0};
    tbl[1]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1, e0};
    tbl[2]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1, e0};
    tbl[3]  = '{1'b0, 1'b0, 2, 1'b0, 1'b1, e0};
    tbl[4]  = '{1'b0, 1'b0, 2, 1'b0, 1'b1, e0};
    tbl[5]  = '{1'b0, 1'b0, 2, 1'b0, 1'b1, e0};
    tbl[6]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, e0};
    tbl[7]  = '{1'b0, 1'b1, 2, 1'b0, 1'b0, e1};
    tbl[8]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, e2};
    tbl[9]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, '0};
    tbl[10] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, '0};

    bus.frame_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear_overflow = 1'b0;
    bus.amplitudes_in = '0;
    bus.freqs_in = '0;
    bus.counter_in = '0;

    repeat (2) @(negedge clk);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_drop_count", 64'(bus.drop_count), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    reset = 1'b0;
    step();

    bus.counter_in = 16'd5;
    bus.amplitudes_in[0] = 24'd10; bus.freqs_in[0] = 9'd3;
    bus.amplitudes_in[1] = 24'd0;  bus.freqs_in[1] = 9'd20;
    bus.amplitudes_in[2] = 24'd30; bus.freqs_in[2] = 9'd40;
    bus.amplitudes_in[3] = 24'd0;  bus.freqs_in[3] = 9'd80;
    bus.amplitudes_in[4] = 24'd0;  bus.freqs_in[4] = 9'd120;
    bus.amplitudes_in[5] = 24'd60; bus.freqs_in[5] = 9'd200;
`ifndef PEAK_FIFO_KEEP_ZERO_EN
    for (int i = 0; i < 11; i++) begin
      bus.frame_valid = tbl[i].fv;
      bus.rd_en = tbl[i].rd;
      step();
      chk("tbl_count", 64'(bus.count), 64'(tbl[i].exp_count));
      chk("tbl_empty", 64'(bus.empty), 64'(tbl[i].exp_empty));
      chk("tbl_busy", 64'(bus.busy), 64'(tbl[i].exp_busy));
      if (!tbl[i].exp_empty) chk("tbl_head", 64'(bus.rd_data), 64'(tbl[i].exp_head));
    end
    bus.rd_en = 1'b0;
`else
    send_frame_and_scan();
    chk("kz_count", 64'(bus.count), 64'd6);
    chk("kz_head0", 64'(bus.rd_data), 64'(e0));
    bus.rd_en = 1'b1;
    step();
    chk("kz_zero_band", 64'(bus.rd_data), 64'(ez));
    repeat (6) step();
    bus.rd_en = 1'b0;
`endif

    // Eleven full frames without reads: 66 candidates, the last two drop
    fill_eleven();
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_drop_count", 64'(bus.drop_count), 64'd2);
    chk("fill_overflow", 64'(bus.overflow), 64'd1);
    bus.rd_en = 1'b1;
    repeat (DEPTH + 1) step();
    bus.rd_en = 1'b0;
    chk("drain_empty", 64'(bus.empty), 64'd1);
    bus.clear_overflow = 1'b1;
    step();
    bus.clear_overflow = 1'b0;

    // Strobe mid-scan is dropped; the strobe at T+PEAKS+1 is taken
    rand_frame(1'b1, 16'h100);
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    repeat (2) step();
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    repeat (PEAKS - 3) step();
    chk("midscan_drop", 64'(bus.drop_count), 64'd1);
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    chk("reaccept_busy", 64'(bus.busy), 64'd1);
    repeat (PEAKS) step();

    // Clear coinciding with a dropped strobe wins
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    repeat (2) step();
    bus.frame_valid = 1'b1;
    bus.clear_overflow = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    bus.clear_overflow = 1'b0;
    chk("clr_overflow", 64'(bus.overflow), 64'd0);
    chk("clr_drop_count", 64'(bus.drop_count), 64'd0);
    repeat (PEAKS) step();

    // Full FIFO with reads held through a scan of all non-zero bands
    bus.rd_en = 1'b1;
    repeat (DEPTH) step();
    bus.rd_en = 1'b0;
    fill_eleven();
    dc_before = m_dc;
    rand_frame(1'b0, 16'h200);
    bus.rd_en = 1'b1;
    send_frame_and_scan();
    bus.rd_en = 1'b0;
    chk("rw_no_drop", 64'(bus.drop_count), 64'(dc_before));
    chk("rw_stays_full_region", 64'(bus.count >= 7'd63), 64'd1);

    // Asynchronous reset in the middle of a scan
    rand_frame(1'b0, 16'h300);
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    repeat (2) step();
    #3 reset = 1'b1;
    #1;
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_overflow", 64'(bus.overflow), 64'd0);
    chk("arst_drop_count", 64'(bus.drop_count), 64'd0);
    chk("arst_full", 64'(bus.full), 64'd0);
    exp_q.delete();
    t_acc = -1000;
    m_ovf = 1'b0;
    m_dc = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    repeat (PEAKS + 2) step();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rand_frame(1'b1, TIME_WIDTH'($urandom));
      bus.frame_valid = ($urandom_range(0, 3) == 0);
      bus.rd_en = ($urandom_range(0, 2) == 0);
      bus.clear_overflow = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.frame_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear_overflow = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
